// File: rtl/nnet_acc_pkg.sv
// Shared definitions for the accumulate-and-requantize layer stages.
// Contents:
//   state_e  - control state encoding (ACCUM collects products, EMIT offers a result)
//   clog2    - ceiling log2 for elaboration-time sizing
//   sat_max / sat_min - signed saturation limits for an activation width
package nnet_acc_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) is 0, so callers needing a counter clamp to 1 bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Largest representable signed value of an out_width-bit activation.
    function automatic longint sat_max(input int out_width);
        return (64'sd1 <<< (out_width - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value of an out_width-bit activation.
    function automatic longint sat_min(input int out_width);
        return -(64'sd1 <<< (out_width - 1));
    endfunction

endpackage

// File: rtl/nnet_acc_requant_if.sv
// Product-in / activation-out handshake bundle of the accumulate stage.
// Signals:
//   prod_data/prod_valid/prod_ready - signed product stream from the multiplier
//   bias                            - signed bias, used on the last product of a group
//   out_data/out_sat/out_valid/out_ready - activation stream to the buffer
// Modports: slave = the accumulate block, master = the upstream/downstream side.
interface nnet_acc_requant_if #(
    parameter int PROD_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) ();

    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [PROD_WIDTH-1:0] bias;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_sat;
    logic                         out_valid;
    logic                         out_ready;

    modport slave (
        input  prod_data, prod_valid, bias, out_ready,
        output prod_ready, out_data, out_sat, out_valid
    );

    modport master (
        output prod_data, prod_valid, bias, out_ready,
        input  prod_ready, out_data, out_sat, out_valid
    );

endinterface

// File: rtl/nnet_requant.sv
// Combinational requantizer: round half toward +inf, arithmetic right shift,
// optional ReLU, saturate to a signed activation.
// Ports:
//   sum_i  - signed wide sum (accumulator + bias)
//   data_o - signed activation
//   sat_o  - high when data_o was clamped to a saturation limit
module nnet_requant
    import nnet_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 41,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 12,
    parameter int RELU      = 1
) (
    input  logic signed [IN_WIDTH-1:0]  sum_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        sat_o
);

    localparam logic signed [IN_WIDTH-1:0] ROUND_C = IN_WIDTH'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [IN_WIDTH-1:0] MAX_C   = IN_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic signed [IN_WIDTH-1:0] MIN_C   = IN_WIDTH'(sat_min(OUT_WIDTH));

    logic signed [IN_WIDTH-1:0] rounded_s;
    logic signed [IN_WIDTH-1:0] shifted_s;

    // Adding half an LSB then flooring via >>> rounds ties toward +inf.
    assign rounded_s = sum_i + ROUND_C;
    assign shifted_s = rounded_s >>> SHIFT;

    // ReLU takes priority over the negative clamp, so a ReLU'd result never flags saturation.
    always_comb begin
        data_o = '0;
        sat_o  = 1'b0;
        if ((RELU != 0) && shifted_s[IN_WIDTH-1]) begin
            data_o = '0;
            sat_o  = 1'b0;
        end else if (shifted_s > MAX_C) begin
            data_o = MAX_C[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end else if (shifted_s < MIN_C) begin
            data_o = MIN_C[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end else begin
            data_o = shifted_s[OUT_WIDTH-1:0];
            sat_o  = 1'b0;
        end
    end

endmodule

// File: rtl/nnet_acc_requant.sv
// Accumulate-and-requantize stage: sums N_IN signed products per output neuron,
// adds the bias on the last product, requantizes and offers one activation.
// Ports:
//   ap_clk   - clock, rising edge
//   ap_rst_n - asynchronous active-low reset
//   s_if     - product/bias input and activation output handshakes (slave side)
//   busy     - a group is partially accumulated or an activation is pending
module nnet_acc_requant
    import nnet_acc_pkg::*;
#(
    parameter int PROD_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 8,
    parameter int N_IN       = 25,
    parameter int SHIFT      = 12,
    parameter int RELU       = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    nnet_acc_requant_if.slave s_if,
    output logic              busy
);

    localparam int              CNT_W    = (clog2(N_IN) > 0) ? clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;
    // Low only while in reset, so prod_ready stays low until the first edge after release.
    logic                        live_q;

    logic                        prod_ready_s;
    logic                        hs_s;
    logic                        last_s;
    logic signed [ACC_WIDTH:0]   sum_s;
    logic signed [OUT_WIDTH-1:0] rq_data_s;
    logic                        rq_sat_s;

    assign prod_ready_s = live_q && (state_q == ST_ACCUM);
    assign hs_s         = s_if.prod_valid && prod_ready_s;
    assign last_s       = (cnt_q == LAST_CNT);
    // Final sum folds in the last product and the bias without touching acc_q first.
    assign sum_s        = (ACC_WIDTH+1)'(acc_q)
                        + (ACC_WIDTH+1)'(s_if.prod_data)
                        + (ACC_WIDTH+1)'(s_if.bias);

    nnet_requant #(
        .IN_WIDTH  (ACC_WIDTH + 1),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT),
        .RELU      (RELU)
    ) u_requant (
        .sum_i  (sum_s),
        .data_o (rq_data_s),
        .sat_o  (rq_sat_s)
    );

    // Next-state: accumulate on handshakes, latch the activation on the last one, wait in EMIT.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (hs_s) begin
                    if (last_s) begin
                        out_data_d = rq_data_s;
                        out_sat_d  = rq_sat_s;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = ST_EMIT;
                    end else begin
                        acc_d = acc_q + ACC_WIDTH'(s_if.prod_data);
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_EMIT: begin
                if (s_if.out_ready) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            live_q     <= 1'b1;
        end
    end

    assign s_if.prod_ready = prod_ready_s;
    assign s_if.out_valid  = (state_q == ST_EMIT);
    assign s_if.out_data   = out_data_q;
    assign s_if.out_sat    = out_sat_q;
    assign busy            = (cnt_q != '0) || (state_q == ST_EMIT);

endmodule

// File: tb/tb_nnet_acc_requant.sv
// Self-checking bench: two instances (RELU=0 and RELU=1) driven with identical
// stimulus and compared against a floor-division reference model.
module tb_nnet_acc_requant;
    import nnet_acc_pkg::*;

    localparam int PW = 32;
    localparam int AW = 40;
    localparam int OW = 8;
    localparam int N  = 4;
    localparam int SH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, busy_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    nnet_acc_requant_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) if_a ();
    nnet_acc_requant_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) if_b ();

    nnet_acc_requant #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
                       .N_IN(N), .SHIFT(SH), .RELU(0)) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_if(if_a.slave), .busy(busy_a));

    nnet_acc_requant #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
                       .N_IN(N), .SHIFT(SH), .RELU(1)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_if(if_b.slave), .busy(busy_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input int b);
        if_a.prod_valid = v; if_a.prod_data = d; if_a.bias = b;
        if_b.prod_valid = v; if_b.prod_data = d; if_b.bias = b;
    endtask

    task automatic set_out_ready(input logic r);
        if_a.out_ready = r;
        if_b.out_ready = r;
    endtask

    // Floor division for a positive divisor.
    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: exact sum, round half up, clamp to the 8-bit signed range.
    function automatic void ref_out(input int p[N], input int b, input bit relu,
                                    output int d, output bit s);
        longint sum, r;
        sum = b;
        for (int i = 0; i < N; i++) sum = sum + p[i];
        r = floor_div(sum + (64'sd1 << (SH - 1)), 64'sd1 << SH);
        if (relu && r < 0) begin d = 0; s = 1'b0; end
        else if (r > 127) begin d = 127; s = 1'b1; end
        else if (r < -128) begin d = -128; s = 1'b1; end
        else begin d = int'(r); s = 1'b0; end
    endfunction

    // Feeds one group with optional bubbles, checks latency and result, holds, releases.
    task automatic run_group(input int p[N], input int b, input int max_bubble,
                             input int hold, input string tag);
        int  ea, eb, gaps, budget;
        bit  sa, sb;
        ref_out(p, b, 1'b0, ea, sa);
        ref_out(p, b, 1'b1, eb, sb);
        set_out_ready(1'b0);
        for (int i = 0; i < N; i++) begin
            gaps = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
            for (int g = 0; g < gaps; g++) begin
                drive(1'b0, int'($urandom), int'($urandom));
                step();
            end
            // Bias is junk except on the last product, where it must be sampled.
            drive(1'b1, p[i], (i == N - 1) ? b : int'($urandom));
            budget = 0;
            while (!if_a.prod_ready && budget < 50) begin step(); budget++; end
            checks++;
            if (budget >= 50) begin
                errors++; $display("FAIL %s ready_timeout: got prod_ready=%b required 1", tag, if_a.prod_ready);
            end
            checks++;
            if (if_a.out_valid !== 1'b0 || if_b.out_valid !== 1'b0) begin
                errors++; $display("FAIL %s early_valid: got %b/%b required 0", tag, if_a.out_valid, if_b.out_valid);
            end
            step();
        end
        drive(1'b0, 0, 0);
        checks++;
        if (if_a.out_valid !== 1'b1 || if_b.out_valid !== 1'b1) begin
            errors++; $display("FAIL %s latency: got out_valid=%b/%b required 1", tag, if_a.out_valid, if_b.out_valid);
        end
        checks++;
        if (if_a.out_data !== OW'(ea) || if_a.out_sat !== sa) begin
            errors++; $display("FAIL %s relu0_data: got %0d sat %b required %0d sat %b", tag, if_a.out_data, if_a.out_sat, ea, sa);
        end
        checks++;
        if (if_b.out_data !== OW'(eb) || if_b.out_sat !== sb) begin
            errors++; $display("FAIL %s relu1_data: got %0d sat %b required %0d sat %b", tag, if_b.out_data, if_b.out_sat, eb, sb);
        end
        // Upstream keeps offering a junk product that must not be consumed.
        for (int h = 0; h < hold; h++) begin
            drive(1'b1, 1000, int'($urandom));
            step();
            checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_data !== OW'(ea) || if_b.out_data !== OW'(eb)
                || if_a.prod_ready !== 1'b0 || if_b.prod_ready !== 1'b0) begin
                errors++; $display("FAIL %s hold: got valid=%b data=%0d/%0d ready=%b required 1 %0d/%0d 0",
                                   tag, if_a.out_valid, if_a.out_data, if_b.out_data, if_a.prod_ready, ea, eb);
            end
        end
        drive(1'b0, 0, 0);
        set_out_ready(1'b1);
        step();
        set_out_ready(1'b0);
        checks++;
        if (if_a.out_valid !== 1'b0 || if_a.prod_ready !== 1'b1 || if_b.prod_ready !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL %s release: got valid=%b ready=%b busy=%b required 0 1 0",
                               tag, if_a.out_valid, if_a.prod_ready, busy_a);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 0, 0);
        set_out_ready(1'b0);
        rst_n = 1'b0;
        step(); step();
        checks++;
        if (if_a.prod_ready !== 1'b0 || if_a.out_valid !== 1'b0 || if_a.out_data !== '0
            || if_a.out_sat !== 1'b0 || busy_a !== 1'b0 || if_b.prod_ready !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_values: got rdy=%b vld=%b data=%0d sat=%b busy=%b required 0 0 0 0 0",
                               if_a.prod_ready, if_a.out_valid, if_a.out_data, if_a.out_sat, busy_a);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_a.prod_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: got %b required 0", if_a.prod_ready);
        end
        step();
        checks++;
        if (if_a.prod_ready !== 1'b1 || if_b.prod_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: got %b/%b required 1", if_a.prod_ready, if_b.prod_ready);
        end
    endtask

    task automatic test_directed();
        int p[N];
        p = '{16, 16, 16, 16};       run_group(p, 0, 0, 0, "basic16");
        p = '{8, 0, 0, 0};           run_group(p, 0, 0, 0, "round_p8");
        p = '{-8, 0, 0, 0};          run_group(p, 0, 0, 0, "round_m8");
        p = '{-9, 0, 0, 0};          run_group(p, 0, 0, 0, "round_m9");
        p = '{0, 0, 0, 0};           run_group(p, 24, 0, 0, "bias24");
        p = '{1000, 1000, 1000, 1000};     run_group(p, 0, 0, 0, "sat_pos");
        p = '{-1000, -1000, -1000, -1000}; run_group(p, 0, 0, 0, "sat_neg");
    endtask

    task automatic test_backpressure();
        int p[N];
        p = '{100, -40, 7, 33};  run_group(p, -5, 0, 5, "bp_a");
        p = '{16, 16, 16, 16};   run_group(p, 0, 0, 0, "bp_b");
    endtask

    task automatic test_bubbles();
        int p[N];
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < N; i++) p[i] = int'($urandom_range(0, 600)) - 300;
            run_group(p, int'($urandom_range(0, 4000)) - 2000, 3, 0, "bubbles");
        end
    endtask

    task automatic test_random();
        int p[N];
        for (int g = 0; g < 15; g++) begin
            for (int i = 0; i < N; i++) p[i] = int'($urandom_range(0, 1200)) - 600;
            run_group(p, int'($urandom_range(0, 4000)) - 2000, 2,
                      int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_reset_mid();
        int p[N];
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16, 0);
            step();
        end
        drive(1'b0, 0, 0);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b/%b required 1", busy_a, busy_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || if_a.prod_ready !== 1'b0 || if_a.out_valid !== 1'b0 || if_a.out_data !== '0) begin
            errors++; $display("FAIL mid_reset: got busy=%b rdy=%b vld=%b data=%0d required 0 0 0 0",
                               busy_a, if_a.prod_ready, if_a.out_valid, if_a.out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        p = '{16, 16, 16, 16};
        run_group(p, 0, 0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int p[3*N];
        int b[3];
        int grp[N];
        int ea[3];
        int eb[3];
        bit sa, sb;
        int idx, nout, cyc, last_cyc;
        for (int g = 0; g < 3; g++) begin
            b[g] = int'($urandom_range(0, 400)) - 200;
            for (int i = 0; i < N; i++) begin
                p[g*N+i] = int'($urandom_range(0, 800)) - 400;
                grp[i]   = p[g*N+i];
            end
            ref_out(grp, b[g], 1'b0, ea[g], sa);
            ref_out(grp, b[g], 1'b1, eb[g], sb);
        end
        idx = 0; nout = 0; cyc = 0; last_cyc = -1;
        set_out_ready(1'b1);
        while (nout < 3 && cyc < 100) begin
            if (if_a.out_valid) begin
                checks++;
                if (if_a.out_data !== OW'(ea[nout]) || if_b.out_data !== OW'(eb[nout])) begin
                    errors++; $display("FAIL b2b_data%0d: got %0d/%0d required %0d/%0d",
                                       nout, if_a.out_data, if_b.out_data, ea[nout], eb[nout]);
                end
                nout++;
                if (nout == 3) last_cyc = cyc;
            end
            if (idx < 3*N) begin
                drive(1'b1, p[idx], b[idx / N]);
                if (if_a.prod_ready) idx++;
            end else begin
                drive(1'b0, 0, 0);
            end
            step();
            cyc++;
        end
        drive(1'b0, 0, 0);
        set_out_ready(1'b0);
        checks++;
        if (last_cyc != 3*(N+1) - 1) begin
            errors++; $display("FAIL b2b_throughput: got third output at cycle %0d required %0d", last_cyc, 3*(N+1) - 1);
        end
    endtask

    initial begin
        drive(1'b0, 0, 0);
        set_out_ready(1'b0);
        test_reset();
        test_directed();
        test_backpressure();
        test_bubbles();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
